// File: rtl/sp_bram_be.sv
// sp_bram_be: single-port block RAM with per-byte write enables, selectable
// write mode (write-first / read-first / no-change), optional output register
// and a post-reset clear engine that fills every word with CLEAR_VALUE.
//
// Handshake: an access is accepted on a rising edge when chip_en && init_done.
// Each accepted access that produces a response raises rd_valid for exactly
// one cycle, 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after the accepting edge,
// with rd_data aligned to it. There is no back-pressure; rd_data holds its
// value between responses.
module sp_bram_be #(
  parameter int                          DATA_WIDTH     = 32,
  parameter int                          NUM_SETS       = 1024,
  parameter int                          BYTE_WIDTH     = 8,
  parameter int                          WRITE_MODE     = 0,
  parameter int                          OUT_REG        = 0,
  parameter int                          CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]       CLEAR_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst_ni,
  input  logic                             chip_en,
  input  logic [$clog2(NUM_SETS)-1:0]      addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_done,
  output logic                             dbg_state
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(NUM_SETS);

  // Explicit last-address compare so the sweep never depends on counter wrap
  // (NUM_SETS need not be a power of two).
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SETS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Storage array: not reset, only initialised by the clear sweep.
  logic [DATA_WIDTH-1:0] r_mem [NUM_SETS];

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_clr_addr;
  logic [AW-1:0]   w_clr_addr_nxt;
  logic            w_clr_we;
  logic            r_init_done;

  logic                  w_accept;
  logic                  w_is_write;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_resp_valid;
  logic [DATA_WIDTH-1:0] w_resp_data;

  logic [NB-1:0]         w_mem_be;
  logic [AW-1:0]         w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // FSM state, clear counter and init_done registers.
  // init_done follows the READY state by one cycle, so it rises on the cycle
  // after the final clear write.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state     <= RESET_STATE;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_init_done <= (r_state == ST_READY);
    end
  end

  // Next-state logic: CLEAR writes one word per cycle until the last address.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt    = ST_READY;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_ONE;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  assign w_accept   = chip_en && r_init_done;
  assign w_is_write = |wr_be;
  assign w_old      = r_mem[addr];

  // Lane merge: enabled lanes come from wr_data, the rest from the array.
  // For a read (wr_be == 0) this is simply the stored word.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Response selection: no-change mode suppresses responses to writes;
  // read-first returns the pre-write word, otherwise the merged word.
  always_comb begin
    w_resp_valid = w_accept && (!w_is_write || (WRITE_MODE != 2));
    w_resp_data  = w_merged;
    if (w_is_write && (WRITE_MODE == 1)) begin
      w_resp_data = w_old;
    end
  end

  // Write-port mux: the clear engine owns the port while sweeping.
  always_comb begin
    w_mem_be    = '0;
    w_mem_addr  = addr;
    w_mem_wdata = wr_data;
    if (w_clr_we) begin
      w_mem_be    = '1;
      w_mem_addr  = r_clr_addr;
      w_mem_wdata = CLEAR_VALUE;
    end else if (w_accept) begin
      w_mem_be    = wr_be;
    end
  end

  // Byte-lane array write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_be[i]) begin
        r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First response stage: data only updates on a response so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_resp_valid;
      if (w_resp_valid) begin
        r_s1_data <= w_resp_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      // Optional output register stage, same hold-on-idle behaviour.
      always_ff @(posedge clk) begin
        if (!rst_ni) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_valid = r_s2_valid;
      assign rd_data  = r_s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = r_s1_valid;
      assign rd_data  = r_s1_data;
    end
  endgenerate

  assign init_done = r_init_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sp_bram_be.sv
// Bench for sp_bram_be: three instances sharing one stimulus stream
// (write-first/OUT_REG=0, read-first/OUT_REG=1, no-change/OUT_REG=0),
// each with its own expected-response queue and monitor.
module tb_sp_bram_be;

  localparam int          DW = 32;
  localparam int          NS = 16;
  localparam int          AW = 4;
  localparam int          NB = 4;
  localparam logic [31:0] CV = 32'hDEAD_BEEF;

  logic          clk;
  logic          rst_ni;
  logic          chip_en;
  logic [AW-1:0] addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1, rd_data2;
  logic          rd_valid0, rd_valid1, rd_valid2;
  logic          init_done0, init_done1, init_done2;
  logic          dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int            due_q0[$], due_q1[$], due_q2[$];

  sp_bram_be #(.DATA_WIDTH(DW), .NUM_SETS(NS), .BYTE_WIDTH(8), .WRITE_MODE(0),
               .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u0 (
    .clk(clk), .rst_ni(rst_ni), .chip_en(chip_en), .addr(addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .init_done(init_done0), .dbg_state(dbg0));

  sp_bram_be #(.DATA_WIDTH(DW), .NUM_SETS(NS), .BYTE_WIDTH(8), .WRITE_MODE(1),
               .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u1 (
    .clk(clk), .rst_ni(rst_ni), .chip_en(chip_en), .addr(addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .init_done(init_done1), .dbg_state(dbg1));

  sp_bram_be #(.DATA_WIDTH(DW), .NUM_SETS(NS), .BYTE_WIDTH(8), .WRITE_MODE(2),
               .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u2 (
    .clk(clk), .rst_ni(rst_ni), .chip_en(chip_en), .addr(addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .init_done(init_done2), .dbg_state(dbg2));

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: pop and compare on every rd_valid pulse.
  always @(negedge clk) begin : mon0
    logic [31:0] e;
    int          c;
    if (rd_valid0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL u0_spurious_valid: got rd_valid=1 data %h expected no response (cycle %0d)", rd_data0, cyc);
      end else begin
        e = exp_q0.pop_front(); c = due_q0.pop_front();
        chk("u0_rd_data", rd_data0, e);
        chk("u0_latency_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [31:0] e;
    int          c;
    if (rd_valid1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL u1_spurious_valid: got rd_valid=1 data %h expected no response (cycle %0d)", rd_data1, cyc);
      end else begin
        e = exp_q1.pop_front(); c = due_q1.pop_front();
        chk("u1_rd_data", rd_data1, e);
        chk("u1_latency_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  always @(negedge clk) begin : mon2
    logic [31:0] e;
    int          c;
    if (rd_valid2 === 1'b1) begin
      if (exp_q2.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL u2_spurious_valid: got rd_valid=1 data %h expected no response (cycle %0d)", rd_data2, cyc);
      end else begin
        e = exp_q2.pop_front(); c = due_q2.pop_front();
        chk("u2_rd_data", rd_data2, e);
        chk("u2_latency_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // Driver: one accepted access. e_new is the write-first / read answer,
  // e_old the read-first answer; the no-change instance answers reads only.
  task automatic access(input logic [AW-1:0] a, input logic [NB-1:0] be,
                        input logic [31:0] d, input logic [31:0] e_new,
                        input logic [31:0] e_old, input bit push_u1);
    chip_en = 1'b1; addr = a; wr_be = be; wr_data = d;
    exp_q0.push_back(e_new); due_q0.push_back(cyc + 1);
    if (push_u1) begin
      exp_q1.push_back(e_old); due_q1.push_back(cyc + 2);
    end
    if (be == '0) begin
      exp_q2.push_back(e_new); due_q2.push_back(cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    chip_en = 1'b0; addr = '0; wr_be = '0; wr_data = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_u0_rd_data"},   rd_data0, 32'h0);
    chk({tag, "_u1_rd_data"},   rd_data1, 32'h0);
    chk({tag, "_u0_rd_valid"},  32'(rd_valid0), 32'h0);
    chk({tag, "_u1_rd_valid"},  32'(rd_valid1), 32'h0);
    chk({tag, "_u2_rd_valid"},  32'(rd_valid2), 32'h0);
    chk({tag, "_u0_init_done"}, 32'(init_done0), 32'h0);
    chk({tag, "_u1_init_done"}, 32'(init_done1), 32'h0);
    chk({tag, "_u0_state"},     32'(dbg0), 32'h0);
  endtask

  // Counts edges after release until init_done; expected on edge NS+1.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (init_done0 === 1'b1) begin
        n = k;
        break;
      end
    end
    chk({tag, "_init_done_edge"}, 32'(n), 32'(NS + 1));
    chk({tag, "_u1_init_done"}, 32'(init_done1), 32'h1);
    chk({tag, "_u2_init_done"}, 32'(init_done2), 32'h1);
  endtask

  initial begin
    rst_ni = 1'b0;
    chip_en = 1'b1; addr = 4'd2; wr_be = 4'hF; wr_data = 32'hCAFE_0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Clear sweep with junk writes driven throughout, reset mid-clear.
    rst_ni = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("mid_clear_init_done_low", 32'(init_done0), 32'h0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_clear_reset");
    rst_ni = 1'b1;
    wait_init("clear");
    idle(1);

    // Back-to-back reads of every word: all hold the clear value
    // (addr 2 included despite the junk writes during CLEAR).
    for (int i = 0; i < NS; i++) begin
      access(AW'(i), 4'h0, 32'h0, CV, CV, 1'b1);
    end
    idle(3);

    // Byte merge on addr 5.
    access(4'd5, 4'hF,    32'h1122_3344, 32'h1122_3344, CV,            1'b1);
    access(4'd5, 4'b0101, 32'hAABB_CCDD, 32'h11BB_33DD, 32'h1122_3344, 1'b1);
    access(4'd5, 4'h0,    32'h0,         32'h11BB_33DD, 32'h11BB_33DD, 1'b1);
    idle(3);

    // Write modes on addr 3, then read-after-write on the next cycle.
    access(4'd3, 4'hF, 32'h0000_00FF, 32'h0000_00FF, CV,            1'b1);
    access(4'd3, 4'hF, 32'h1234_5678, 32'h1234_5678, 32'h0000_00FF, 1'b1);
    idle(3);
    chk("u2_no_change_hold", rd_data2, 32'h11BB_33DD);
    access(4'd3, 4'h0, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b1);

    // chip_en low with write enables set must not touch the array.
    chip_en = 1'b0; addr = 4'd3; wr_be = 4'hF; wr_data = 32'h0;
    @(posedge clk); #1;
    access(4'd3, 4'h0, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b1);

    // Single top-lane write at addr 7, then read back; top address read.
    access(4'd7, 4'b1000, 32'hFF00_0000, 32'hFFAD_BEEF, CV, 1'b1);
    access(4'd7, 4'h0,    32'h0,         32'hFFAD_BEEF, 32'hFFAD_BEEF, 1'b1);
    access(4'd15, 4'h0,   32'h0,         CV, CV, 1'b1);
    idle(4);
    chk("u0_queue_drained", 32'(exp_q0.size()), 32'h0);
    chk("u1_queue_drained", 32'(exp_q1.size()), 32'h0);
    chk("u2_queue_drained", 32'(exp_q2.size()), 32'h0);

    // Reset mid-pipeline: u1's response is still in flight and must be dropped.
    access(4'd0, 4'h0, 32'h0, CV, CV, 1'b0);
    rst_ni = 1'b0; chip_en = 1'b0; wr_be = '0;
    @(posedge clk); #1;
    check_reset_outputs("mid_pipe_reset");
    @(posedge clk); #1;
    chk("mid_pipe_u1_valid_after", 32'(rd_valid1), 32'h0);
    rst_ni = 1'b1;
    wait_init("reclear");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
